// File: rtl/present_sbox_layer_seq.sv
// Nibble-serial sequencer for the 2-share masked PRESENT S-box layer.
// Streams a shared 64-bit state through an external S-box gadget pipeline
// of depth SBOX_LAT, one nibble per cycle, and reassembles the shared result.
// Optional build macro: PRESENT_SBOX_SEQ_ZEROIZE_EN forces the gadget inputs
// to zero outside FEED and clears the collection registers at start.
//
// state | meaning
// IDLE  | waiting for start; result held on state_out*
// FEED  | issuing nibbles 0..15 to the S-box pipeline
// DRAIN | waiting for the remaining in-flight nibbles to return
module present_sbox_layer_seq #(
    parameter int SBOX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] state_in0,
    input  logic [63:0] state_in1,
    output logic        busy,
    output logic        done,
    output logic [63:0] state_out0,
    output logic [63:0] state_out1,
    output logic        sbox_en,
    output logic [3:0]  sbox_in0,
    output logic [3:0]  sbox_in1,
    input  logic [3:0]  sbox_out0,
    input  logic [3:0]  sbox_out1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [63:0]          src0_q, src0_d, src1_q, src1_d;
    logic [63:0]          dst0_q, dst0_d, dst1_q, dst1_d;
    logic [63:0]          out0_q, out0_d, out1_q, out1_d;
    logic [3:0]           cnt_in_q, cnt_in_d, cnt_out_q, cnt_out_d;
    logic [SBOX_LAT-1:0]  vld_q, vld_d;
    logic                 done_q, done_d;
    logic                 issue, vld_out, last_out;

    assign issue    = (state_q == ST_FEED);
    assign vld_out  = vld_q[SBOX_LAT-1];
    assign last_out = vld_out && (cnt_out_q == 4'd15);

    // Issue-flag delay line: a flag leaves the top exactly SBOX_LAT cycles after issue
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < SBOX_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Next-state, nibble issue and result collection
    always_comb begin
        state_d   = state_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        dst0_d    = dst0_q;
        dst1_d    = dst1_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        cnt_in_d  = cnt_in_q;
        cnt_out_d = cnt_out_q;
        done_d    = 1'b0;

        // Returning nibbles enter at the top so nibble i ends at bits [4i+3:4i]
        if (vld_out) begin
            dst0_d    = {sbox_out0, dst0_q[63:4]};
            dst1_d    = {sbox_out1, dst1_q[63:4]};
            cnt_out_d = cnt_out_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src0_d    = state_in0;
                    src1_d    = state_in1;
                    cnt_in_d  = 4'd0;
                    cnt_out_d = 4'd0;
`ifdef PRESENT_SBOX_SEQ_ZEROIZE_EN
                    dst0_d    = '0;
                    dst1_d    = '0;
`endif
                    state_d   = ST_FEED;
                end
            end
            ST_FEED: begin
                src0_d   = {4'h0, src0_q[63:4]};
                src1_d   = {4'h0, src1_q[63:4]};
                cnt_in_d = cnt_in_q + 4'd1;
                if (cnt_in_q == 4'd15) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_out) begin
                    out0_d  = dst0_d;
                    out1_d  = dst1_d;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any nibbles still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src0_q    <= '0;
            src1_q    <= '0;
            dst0_q    <= '0;
            dst1_q    <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
            vld_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            dst0_q    <= dst0_d;
            dst1_q    <= dst1_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            cnt_in_q  <= cnt_in_d;
            cnt_out_q <= cnt_out_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign sbox_en    = busy;
    assign done       = done_q;
    assign state_out0 = out0_q;
    assign state_out1 = out1_q;

`ifdef PRESENT_SBOX_SEQ_ZEROIZE_EN
    // Gadget inputs only carry share data while nibbles are being issued
    assign sbox_in0 = issue ? src0_q[3:0] : 4'h0;
    assign sbox_in1 = issue ? src1_q[3:0] : 4'h0;
`else
    // After a run the shift-out has left src at zero, so IDLE drives 0 anyway
    assign sbox_in0 = src0_q[3:0];
    assign sbox_in1 = src1_q[3:0];
`endif

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Bench for present_sbox_layer_seq: three instances (SBOX_LAT 2, 1, 4) share
// start/data; each has a behavioural S-box pipeline that is either a pure
// delay (identity) or a re-masking 2-share PRESENT S-box.
module tb_present_sbox_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] state_in0 = '0;
    logic [63:0] state_in1 = '0;
    logic        masked = 1'b0;

    logic [2:0]  busy_v, done_v, en_v;
    logic [63:0] out0_v [3];
    logic [63:0] out1_v [3];
    logic [3:0]  si0_v [3];
    logic [3:0]  si1_v [3];
    logic [3:0]  so0_v [3];
    logic [3:0]  so1_v [3];

    int          cyc = 0;
    int          e0 = 0;
    int          total = 0;
    int          bad = 0;
    logic [2:0]  done_seen = '0;
    int          done_cnt [3];
    int          done_cyc [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sbox_f(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] slayer(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox_f(x[4*n +: 4]);
        return r;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        logic [3:0] p0 [LAT];
        logic [3:0] p1 [LAT];
        logic [3:0] y, m;

        present_sbox_layer_seq #(.SBOX_LAT(LAT)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .state_in0  (state_in0),
            .state_in1  (state_in1),
            .busy       (busy_v[gi]),
            .done       (done_v[gi]),
            .state_out0 (out0_v[gi]),
            .state_out1 (out1_v[gi]),
            .sbox_en    (en_v[gi]),
            .sbox_in0   (si0_v[gi]),
            .sbox_in1   (si1_v[gi]),
            .sbox_out0  (so0_v[gi]),
            .sbox_out1  (so1_v[gi])
        );

        // Behavioural gadget pipeline: LAT register stages
        always @(posedge clk) begin
            if (masked) begin
                y = sbox_f(si0_v[gi] ^ si1_v[gi]);
                m = 4'($urandom);
                p0[0] <= m;
                p1[0] <= y ^ m;
            end else begin
                p0[0] <= si0_v[gi];
                p1[0] <= si1_v[gi];
            end
            for (int i = 1; i < LAT; i++) begin
                p0[i] <= p0[i-1];
                p1[i] <= p1[i-1];
            end
        end

        assign so0_v[gi] = p0[LAT-1];
        assign so1_v[gi] = p1[LAT-1];
    end

    // Record done pulses just after each edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                done_seen[i] = 1'b1;
                done_cnt[i]  = done_cnt[i] + 1;
                done_cyc[i]  = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        state_in0 = a;
        state_in1 = b;
        start     = 1'b1;
        done_seen = '0;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_done(input logic [2:0] mask);
        int n;
        n = 0;
        while (n < 60 && ((done_seen & mask) != mask)) begin
            @(negedge clk);
            n++;
        end
        if ((done_seen & mask) != mask) chk("done_timeout", 64'(done_seen & mask), 64'(mask));
    endtask

    task automatic check_layer(input string tag, input logic [63:0] a, input logic [63:0] b);
        for (int i = 0; i < 3; i++) begin
            if (masked)
                chk($sformatf("%s_xor%0d", tag, i), out0_v[i] ^ out1_v[i], slayer(a ^ b));
            else begin
                chk($sformatf("%s_sh0_%0d", tag, i), out0_v[i], a);
                chk($sformatf("%s_sh1_%0d", tag, i), out1_v[i], b);
            end
            chk($sformatf("%s_lat%0d", tag, i), 64'(done_cyc[i] - e0), 64'(16 + lat_of(i)));
            chk($sformatf("%s_ndone%0d", tag, i), 64'(done_cnt[i]), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] a, b, c, d;
        int n;
        for (int i = 0; i < 3; i++) begin
            done_cnt[i] = 0;
            done_cyc[i] = 0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ctl%0d", i), 64'({busy_v[i], done_v[i], en_v[i]}), 64'd0);
            chk($sformatf("rst_out%0d", i), out0_v[i] | out1_v[i], 64'd0);
            chk($sformatf("rst_sin%0d", i), 64'({si0_v[i], si1_v[i]}), 64'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_ctl", 64'({busy_v, en_v, done_v}), 64'd0);
        end

        // Identity pass-through on all latencies
        a = 64'h0123456789ABCDEF;
        b = 64'hFFFF0000FFFF0000;
        launch(a, b);
        chk("nib0", 64'({si0_v[0], si1_v[0]}), 64'h0F0);
        chk("busy_rise", 64'({busy_v, en_v}), 64'h3F);
        @(posedge clk); #1;
        chk("nib1", 64'({si0_v[0], si1_v[0]}), 64'h0E0);
        wait_done(3'b111);
        check_layer("ident", a, b);
        @(negedge clk);
        chk("done_pulse", 64'({done_v, busy_v, en_v}), 64'd0);

        // Random identity
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        launch(a, b);
        wait_done(3'b111);
        check_layer("ident_rnd", a, b);

        // Masked S-box layer, zero unmasked input
        masked = 1'b1;
        a = {$urandom, $urandom};
        launch(a, a);
        wait_done(3'b111);
        for (int i = 0; i < 3; i++)
            chk($sformatf("cccc%0d", i), out0_v[i] ^ out1_v[i], 64'hCCCCCCCCCCCCCCCC);

        // Masked, arbitrary shares
        for (int t = 0; t < 4; t++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            launch(a, b);
            wait_done(3'b111);
            check_layer("mask_rnd", a, b);
        end

        // Start mid-FEED ignored, then back-to-back start in the done cycle
        masked = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        launch(a, b);
        repeat (4) @(posedge clk);
        #1;
        start     = 1'b1;
        state_in0 = ~a;
        state_in1 = ~b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_ign", 64'(busy_v[0]), 64'd1);
        chk("nib5", 64'({si0_v[0], si1_v[0]}), 64'({a[23:20], b[23:20]}));
        n = 0;
        while (n < 40 && !done_v[0]) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done", 64'(done_v[0]), 64'd1);
        chk("b2b_first0", out0_v[0], a);
        chk("b2b_first1", out1_v[0], b);
        chk("b2b_first_lat", 64'(done_cyc[0] - e0), 64'd18);
        c = {$urandom, $urandom};
        d = {$urandom, $urandom};
        e0        = done_cyc[0];
        state_in0 = c;
        state_in1 = d;
        start     = 1'b1;
        done_seen = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3'b001);
        chk("b2b_gap", 64'(done_cyc[0] - e0), 64'd19);
        chk("b2b_second0", out0_v[0], c);
        chk("b2b_second1", out1_v[0], d);
        repeat (30) @(negedge clk);

        // Reset mid-operation
        launch(a, b);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_ctl%0d", i), 64'({busy_v[i], done_v[i], en_v[i]}), 64'd0);
            chk($sformatf("mid_out%0d", i), out0_v[i] | out1_v[i], 64'd0);
            chk($sformatf("mid_sin%0d", i), 64'({si0_v[i], si1_v[i]}), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("mid_nodone", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 64'd0);
        masked = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        launch(a, b);
        wait_done(3'b111);
        check_layer("post_rst", a, b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
